// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 4-stage IEEE-754-style multiplier (unpack, multiply, normalise, round/pack), falling-edge clocked.
// Define FPM_RNE_EN for round-to-nearest-even; without it the mantissa is truncated.
module fp_mul_pipe #(
   parameter  int unsigned EXP_W = 8,
   parameter  int unsigned MAN_W = 23,
   localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
   input  logic         clkn_i,
   input  logic         rstn_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] result_o,
   output logic         nv_o,
   output logic         ovf_o,
   output logic         unf_o
);
   localparam int unsigned PW = 2*MAN_W + 2;
   localparam int unsigned EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W-1)) - 1);
   localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EZERO = '0;
   localparam logic signed [EW-1:0] EONE  = EW'(1);

   logic w_adv;

   // Stage 1 inputs
   logic             w_sa, w_sb;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_a_zero, w_a_inf, w_a_nan, w_a_norm;
   logic             w_b_zero, w_b_inf, w_b_nan, w_b_norm;

   // Pipeline registers
   logic             r1_valid, r1_sign, r1_nv, r1_inf, r1_zero;
   logic [EXP_W-1:0] r1_ea, r1_eb;
   logic [MAN_W:0]   r1_ma, r1_mb;

   logic                 r2_valid, r2_sign, r2_nv, r2_inf, r2_zero;
   logic [PW-1:0]        r2_prod;
   logic signed [EW-1:0] r2_e;

   logic                 r3_valid, r3_sign, r3_nv, r3_inf, r3_zero;
   logic [MAN_W-1:0]     r3_man;
   logic                 r3_g, r3_s;
   logic signed [EW-1:0] r3_e;

   logic         r4_valid, r4_nv, r4_ovf, r4_unf;
   logic [W-1:0] r4_res;

   // Combinational per-stage results
   logic signed [EW-1:0] w_sum_e;
   logic [MAN_W-1:0]     w_n_man;
   logic                 w_n_g, w_n_s;
   logic signed [EW-1:0] w_n_e;
   logic [MAN_W-1:0]     w_r_man;
   logic signed [EW-1:0] w_r_e;
   logic [W-1:0]         w_res;
   logic                 w_nv, w_ovf, w_unf;

   assign w_adv   = ~r4_valid | ready_i;
   assign ready_o = w_adv;

   assign {w_sa, w_ea, w_fa} = a_i;
   assign {w_sb, w_eb, w_fb} = b_i;

   // Subnormals (exp==0) are flushed to zero on entry
   assign w_a_zero = (w_ea == '0);
   assign w_a_inf  = (&w_ea) & (w_fa == '0);
   assign w_a_nan  = (&w_ea) & (|w_fa);
   assign w_a_norm = ~w_a_zero & ~(&w_ea);
   assign w_b_zero = (w_eb == '0);
   assign w_b_inf  = (&w_eb) & (w_fb == '0);
   assign w_b_nan  = (&w_eb) & (|w_fb);
   assign w_b_norm = ~w_b_zero & ~(&w_eb);

   assign w_sum_e = $signed({2'b00, r1_ea}) + $signed({2'b00, r1_eb}) - BIAS;

   always_comb begin
      if (r2_prod[PW-1]) begin
         w_n_man = r2_prod[2*MAN_W -: MAN_W];
         w_n_g   = r2_prod[MAN_W];
         w_n_s   = |r2_prod[MAN_W-1:0];
         w_n_e   = r2_e + EONE;
      end else begin
         w_n_man = r2_prod[2*MAN_W-1 -: MAN_W];
         w_n_g   = r2_prod[MAN_W-1];
         w_n_s   = |r2_prod[MAN_W-2:0];
         w_n_e   = r2_e;
      end
   end

`ifdef FPM_RNE_EN
   logic             w_inc;
   logic [MAN_W:0]   w_man_c;
   assign w_inc   = r3_g & (r3_s | r3_man[0]);
   assign w_man_c = {1'b0, r3_man} + (MAN_W+1)'(w_inc);
   // An all-ones mantissa rounding up wraps to zero, so only the exponent needs the carry
   assign w_r_man = w_man_c[MAN_W-1:0];
   assign w_r_e   = w_man_c[MAN_W] ? (r3_e + EONE) : r3_e;
`else
   logic w_unused_gs;
   assign w_unused_gs = r3_g | r3_s;
   assign w_r_man     = r3_man;
   assign w_r_e       = r3_e;
`endif

   always_comb begin
      w_res = {r3_sign, w_r_e[EXP_W-1:0], w_r_man};
      w_nv  = 1'b0;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      if (r3_nv) begin
         w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         w_nv  = 1'b1;
      end else if (r3_inf) begin
         w_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (r3_zero) begin
         w_res = {r3_sign, {(W-1){1'b0}}};
      end else if (w_r_e >= EMAX) begin
         w_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_ovf = 1'b1;
      end else if (w_r_e <= EZERO) begin
         w_res = {r3_sign, {(W-1){1'b0}}};
         w_unf = 1'b1;
      end
   end

   always_ff @(negedge clkn_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r1_valid <= 1'b0; r1_sign <= 1'b0; r1_nv <= 1'b0; r1_inf <= 1'b0; r1_zero <= 1'b0;
         r1_ea    <= '0;   r1_eb   <= '0;   r1_ma <= '0;   r1_mb  <= '0;
         r2_valid <= 1'b0; r2_sign <= 1'b0; r2_nv <= 1'b0; r2_inf <= 1'b0; r2_zero <= 1'b0;
         r2_prod  <= '0;   r2_e    <= '0;
         r3_valid <= 1'b0; r3_sign <= 1'b0; r3_nv <= 1'b0; r3_inf <= 1'b0; r3_zero <= 1'b0;
         r3_man   <= '0;   r3_g    <= 1'b0; r3_s  <= 1'b0; r3_e   <= '0;
         r4_valid <= 1'b0; r4_nv   <= 1'b0; r4_ovf <= 1'b0; r4_unf <= 1'b0;
         r4_res   <= '0;
      end else if (w_adv) begin
         r1_valid <= valid_i;
         r1_sign  <= w_sa ^ w_sb;
         r1_nv    <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
         r1_inf   <= w_a_inf | w_b_inf;
         r1_zero  <= w_a_zero | w_b_zero;
         r1_ea    <= w_ea;
         r1_eb    <= w_eb;
         r1_ma    <= {w_a_norm, w_fa};
         r1_mb    <= {w_b_norm, w_fb};

         r2_valid <= r1_valid;
         r2_sign  <= r1_sign;
         r2_nv    <= r1_nv;
         r2_inf   <= r1_inf;
         r2_zero  <= r1_zero;
         r2_prod  <= PW'(r1_ma) * PW'(r1_mb);
         r2_e     <= w_sum_e;

         r3_valid <= r2_valid;
         r3_sign  <= r2_sign;
         r3_nv    <= r2_nv;
         r3_inf   <= r2_inf;
         r3_zero  <= r2_zero;
         r3_man   <= w_n_man;
         r3_g     <= w_n_g;
         r3_s     <= w_n_s;
         r3_e     <= w_n_e;

         // A bubble leaves the previous result in place; flags only accompany a valid result
         r4_valid <= r3_valid;
         if (r3_valid) r4_res <= w_res;
         r4_nv    <= r3_valid & w_nv;
         r4_ovf   <= r3_valid & w_ovf;
         r4_unf   <= r3_valid & w_unf;
      end
   end

   assign valid_o  = r4_valid;
   assign result_o = r4_res;
   assign nv_o     = r4_nv;
   assign ovf_o    = r4_ovf;
   assign unf_o    = r4_unf;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed-vector bench for fp_mul_pipe in FP32 and FP16 configurations.
// Expected values are hand-computed; rounding-dependent vectors follow FPM_RNE_EN.
module tb_fp_mul_pipe;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  flg;   // {nv, ovf, unf}
   } vec_t;

`ifdef FPM_RNE_EN
   localparam logic [31:0] TIE_EXP   = 32'h3FC00002;
   localparam logic [31:0] CARRY_EXP = 32'h40000000;
`else
   localparam logic [31:0] TIE_EXP   = 32'h3FC00001;
   localparam logic [31:0] CARRY_EXP = 32'h3FFFFFFF;
`endif

   localparam int N32 = 14;
   localparam int N16 = 3;

   vec_t v32 [N32];
   vec_t v16 [N16];

   int n_pass  = 0;
   int n_total = 0;

   logic clkn = 1'b1;
   always #5 clkn = ~clkn;

   logic        rstn32, v32_i, rdy32_o, v32_o, rdy32_i, nv32, ovf32, unf32;
   logic [31:0] a32, b32, res32;
   logic        rstn16, v16_i, rdy16_o, v16_o, rdy16_i, nv16, ovf16, unf16;
   logic [15:0] a16, b16, res16;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_fp32 (
      .clkn_i(clkn), .rstn_i(rstn32), .valid_i(v32_i), .ready_o(rdy32_o),
      .a_i(a32), .b_i(b32), .valid_o(v32_o), .ready_i(rdy32_i),
      .result_o(res32), .nv_o(nv32), .ovf_o(ovf32), .unf_o(unf32)
   );

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_fp16 (
      .clkn_i(clkn), .rstn_i(rstn16), .valid_i(v16_i), .ready_o(rdy16_o),
      .a_i(a16), .b_i(b16), .valid_o(v16_o), .ready_i(rdy16_i),
      .result_o(res16), .nv_o(nv16), .ovf_o(ovf16), .unf_o(unf16)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Called just after a falling edge; presents one operand pair and times its result.
   task automatic run_one(input bit is16, input vec_t v, input string name);
      int edges;
      if (is16) begin a16 = v.a[15:0]; b16 = v.b[15:0]; v16_i = 1'b1; end
      else      begin a32 = v.a;       b32 = v.b;       v32_i = 1'b1; end
      #1;
      check({name, "_rdy"}, is16 ? rdy16_o : rdy32_o, 64'd1);
      @(negedge clkn); #1;
      v32_i = 1'b0;
      v16_i = 1'b0;
      edges = 1;
      while (!(is16 ? v16_o : v32_o) && edges < 12) begin
         @(negedge clkn); #1;
         edges++;
      end
      check({name, "_lat"}, edges, 64'd4);
      if (is16) check(name, {res16, nv16, ovf16, unf16}, {v.res[15:0], v.flg});
      else      check(name, {res32, nv32, ovf32, unf32}, {v.res, v.flg});
      @(negedge clkn); #1;
   endtask

   // Streams all FP32 vectors with a 3-cycle ready_i drop; optional random valid_i gaps.
   task automatic stream32(input bit gaps, input int stall_at);
      int in_i = 0, out_i = 0, cyc = 0, bad_stall = 0, stall_seen = 0, extra = 0;
      bit took;
      while (out_i < N32 && cyc < 400) begin
         rdy32_i = !(cyc >= stall_at && cyc < stall_at + 3);
         v32_i   = (in_i < N32) && (!gaps || $urandom_range(0, 2) != 0);
         if (v32_i) begin a32 = v32[in_i].a; b32 = v32[in_i].b; end
         #1;
         if (!rdy32_i && v32_o) begin
            if (rdy32_o) bad_stall++;
            else         stall_seen++;
         end
         took = v32_i && rdy32_o;
         if (v32_o && rdy32_i) begin
            check($sformatf("stream%0d_g%0d", out_i, gaps), {res32, nv32, ovf32, unf32},
                  {v32[out_i].res, v32[out_i].flg});
            out_i++;
         end
         @(negedge clkn); #1;
         if (took) in_i++;
         cyc++;
      end
      v32_i   = 1'b0;
      rdy32_i = 1'b1;
      check($sformatf("stream_count_g%0d", gaps), out_i, N32);
      check($sformatf("stall_ready_g%0d", gaps), bad_stall, 0);
      if (!gaps) check("stall_seen", stall_seen > 0, 64'd1);
      repeat (6) begin
         #1;
         if (v32_o) extra++;
         @(negedge clkn); #1;
      end
      check($sformatf("stream_extra_g%0d", gaps), extra, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int seen;
      v32[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
      v32[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000};
      v32[2]  = '{32'h3F800001, 32'h3FC00000, TIE_EXP,      3'b000};
      v32[3]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100};
      v32[4]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b100};
      v32[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
      v32[6]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
      v32[7]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
      v32[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000};
      v32[9]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000};
      v32[10] = '{32'h40400000, 32'h40400000, 32'h41100000, 3'b000};
      v32[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
      v32[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000};
      v32[13] = '{32'h3FFFFFFE, 32'h3F800001, CARRY_EXP,    3'b000};

      v16[0]  = '{32'h00003C00, 32'h00004000, 32'h00004000, 3'b000};
      v16[1]  = '{32'h00007BFF, 32'h00004000, 32'h00007C00, 3'b010};
      v16[2]  = '{32'h00004200, 32'h00004200, 32'h00004880, 3'b000};

      rstn32 = 1'b0; rstn16 = 1'b0;
      v32_i = 1'b0; v16_i = 1'b0; rdy32_i = 1'b1; rdy16_i = 1'b1;
      a32 = '0; b32 = '0; a16 = '0; b16 = '0;
      repeat (2) @(negedge clkn);
      #1;
      check("reset32", {v32_o, rdy32_o, res32, nv32, ovf32, unf32}, {2'b01, 32'h0, 3'b000});
      check("reset16", {v16_o, rdy16_o, res16, nv16, ovf16, unf16}, {2'b01, 16'h0, 3'b000});
      rstn32 = 1'b1; rstn16 = 1'b1;
      @(negedge clkn); #1;

      for (int i = 0; i < N32; i++) run_one(1'b0, v32[i], $sformatf("fp32_v%0d", i));
      for (int i = 0; i < N16; i++) run_one(1'b1, v16[i], $sformatf("fp16_v%0d", i));

      stream32(1'b0, 6);
      stream32(1'b1, 9);

      // FP16 reset with three products in flight
      for (int i = 0; i < N16; i++) begin
         a16 = v16[i].a[15:0]; b16 = v16[i].b[15:0]; v16_i = 1'b1;
         @(negedge clkn); #1;
      end
      v16_i  = 1'b0;
      rstn16 = 1'b0;
      #2;
      check("midrst_clear", {v16_o, res16, nv16, ovf16, unf16}, {1'b0, 16'h0, 3'b000});
      @(negedge clkn); #1;
      rstn16 = 1'b1;
      seen = 0;
      repeat (8) begin
         if (v16_o) seen++;
         @(negedge clkn); #1;
      end
      check("midrst_no_stale", seen, 0);
      run_one(1'b1, v16[0], "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised IEEE-754-style floating-point multiplier with a fixed 4-stage pipeline.
- Successor to the team's fixed FP32 multiplier. Adds:
  - configurable exponent and mantissa widths (FP32, FP16 and BF16 from one RTL);
  - valid/ready flow control with global stall;
  - special-value handling (inf, NaN, inf*0);
  - exception flags;
  - round-to-nearest-even.
- Sits in the NLA datapath between operand fetch and the approximation accumulators.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1, derived internally).
- MAN_W, 23, stored mantissa field width (hidden bit not included).
- Derived: W = 1+EXP_W+MAN_W, the operand and result width.

Ports:
- clkn_i  in  1  clock; all state updates on the falling edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  operand pair valid.
- ready_o  out  1  block can accept; equals advance.
- a_i  in  W  operand A {sign, exp, man}.
- b_i  in  W  operand B.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- result_o  out  W  product.
- nv_o  out  1  invalid operation (NaN operand or inf*0).
- ovf_o  out  1  overflow to infinity.
- unf_o  out  1  underflow flushed to zero.

Behaviour:
- Reset: all pipeline registers clear. valid_o, result_o, nv_o, ovf_o and unf_o are 0.
- Flow control:
  - advance = ~valid_o | ready_i. ready_o = advance.
  - When advance=0 every stage holds, including bubbles.
  - An input transfer happens when valid_i & ready_o at a falling edge.
- Latency: exactly 4 edges from transfer to valid_o when there is no stall. Throughput is 1 per cycle.
- Result and flags are held stable while valid_o=1 and ready_i=0.
- Per-stage valid bits propagate alongside the data. Bubbles pass through with valid=0 and must not corrupt held output.
- S1, unpack/classify:
  - exp==0 is treated as zero; subnormals are flushed (DAZ).
  - exp all-ones with man==0 is inf. exp all-ones with man!=0 is NaN.
  - Hidden bit is set for normal operands.
  - sign = sa^sb.
- S2: registers the (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits. Exponent sum e = ea+eb-bias is held in signed EXP_W+2 bits.
- S3, normalise:
  - If product MSB=1, take the upper MAN_W bits below the MSB and e+1; otherwise shift by one.
  - Extract guard bit G and sticky S (OR of all lower bits).
- S4, round/pack:
  - Round-to-nearest-even: increment when G & (S | lsb).
  - A mantissa carry-out sets mantissa to 0 and e+1.
- Exception priority, applied in S4:
  1. NaN operand, or inf*0: result = canonical qNaN {0, all-ones, 1, zeros}, nv=1.
  2. Either operand inf: {sign, all-ones, 0}.
  3. Either operand zero: {sign, 0, 0}, no flags.
  4. Final e >= 2^EXP_W-1: {sign, all-ones, 0}, ovf=1.
  5. Final e <= 0: {sign, 0, 0}, unf=1.
- Flags are per-result and valid only with valid_o; they are 0 otherwise.
- Reset asserted mid-operation: all in-flight results are discarded and no output appears after release. The first accepted input after reset returns exactly 4 cycles later.

Optional Feature:
- FPM_RNE_EN defined: round-to-nearest-even as above.
- FPM_RNE_EN undefined:
  - truncation (G and S ignored, no rounding increment), matching the legacy multiplier's numerics;
  - rounding carry path removed;
  - latency, flags and special cases unchanged.

Test Plan:
- FP32, ready_i=1: 0x3FC00000*0x40000000 -> 0x40400000, valid_o exactly 4 edges after transfer. 0xC0000000*0x40400000 -> 0xC0C00000.
- Tie rounding: 0x3F800001*0x3FC00000 -> 0x3FC00002 with FPM_RNE_EN; 0x3FC00001 without.
- Specials:
  - 0x00000000*0x7F800000 -> 0x7FC00000, nv=1.
  - 0x7FC00000*0x3F800000 -> 0x7FC00000, nv=1.
  - 0xFF800000*0x40000000 -> 0xFF800000, no flags.
- Range: 0x7F000000*0x7F000000 -> 0x7F800000, ovf=1. 0x00800000*0x00800000 -> 0x00000000, unf=1. Subnormal 0x00000001*0x3F800000 -> 0x00000000, no flags.
- Backpressure: stream 8 back-to-back products, drop ready_i for 3 cycles mid-stream -> ready_o=0 during the stall, no loss or duplication, results in order. Repeat with random valid_i gaps.
- EXP_W=5, MAN_W=10 (FP16): 0x3C00*0x4000 -> 0x4000. 0x7BFF*0x4000 -> 0x7C00, ovf=1. Mid-stream rstn_i pulse -> valid_o=0 and no stale outputs afterwards.
